// File: rtl/phi_n_state_pkg.sv
// Shared definitions for the phi_n state schedule controller: state codes,
// schedule FSM states, default widths and a state-code legalising helper.
package phi_n_state_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] STATE_NORMAL     = 3'd0;
    localparam logic [STATE_W-1:0] STATE_MEDITATION = 3'd4;
    // Legal state codes are 0..STATE_CODE_MAX; anything above falls back to NORMAL.
    localparam logic [STATE_W-1:0] STATE_CODE_MAX   = STATE_MEDITATION;

    localparam int THETA_W_DEF       = 18;
    localparam int ENTRIES_DEF       = 16;
    localparam int DWELL_W_DEF       = 16;
    localparam int ALIGN_TIMEOUT_DEF = 1000;

    typedef enum logic [1:0] {
        FSM_IDLE,
        FSM_DWELL,
        FSM_ALIGN,
        FSM_FINISH
    } sched_fsm_e;

    function automatic logic [STATE_W-1:0] legal_state(input logic [STATE_W-1:0] code);
        return (code > STATE_CODE_MAX) ? STATE_NORMAL : code;
    endfunction

endpackage

// File: rtl/schedule_table_ram.sv
// Schedule table: ENTRIES x (state, dwell) register file, one synchronous
// write port and one asynchronous read port.
module schedule_table_ram
    import phi_n_state_pkg::*;
#(
    parameter int  ENTRIES = ENTRIES_DEF,
    parameter int  DWELL_W = DWELL_W_DEF,
    localparam int ADDR_W  = $clog2(ENTRIES)
) (
    input  logic               clk,
    input  logic               wr_en_i,
    input  logic [ADDR_W-1:0]  wr_addr_i,
    input  logic [STATE_W-1:0] wr_state_i,
    input  logic [DWELL_W-1:0] wr_dwell_i,
    input  logic [ADDR_W-1:0]  rd_addr_i,
    output logic [STATE_W-1:0] rd_state_o,
    output logic [DWELL_W-1:0] rd_dwell_o
);

    typedef struct packed {
        logic [STATE_W-1:0] state;
        logic [DWELL_W-1:0] dwell;
    } entry_t;

    entry_t mem_q [ENTRIES];

    // Table write port.
    // NOTE: the storage array has no reset branch; its contents must survive
    // a controller reset, and leaving it out keeps it a plain register file.
    // NOTE: clocked state is always assigned with <= so every flop samples the
    // pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= '{state: wr_state_i, dwell: wr_dwell_i};
        end
    end

    assign rd_state_o = mem_q[rd_addr_i].state;
    assign rd_dwell_o = mem_q[rd_addr_i].dwell;

endmodule

// File: rtl/state_schedule_controller.sv
// Steps the processor state_select through the programmed (state, dwell)
// table. Dwell is counted in 4 kHz ticks; with sync_to_theta each change
// waits for an upward theta zero crossing, bounded by ALIGN_TIMEOUT ticks.
module state_schedule_controller
    import phi_n_state_pkg::*;
#(
    parameter int  WIDTH         = THETA_W_DEF,
    parameter int  ENTRIES       = ENTRIES_DEF,
    parameter int  DWELL_W       = DWELL_W_DEF,
    parameter int  ALIGN_TIMEOUT = ALIGN_TIMEOUT_DEF,
    localparam int ADDR_W        = $clog2(ENTRIES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_4khz_en,
    input  logic signed [WIDTH-1:0] theta_in,
    input  logic                    cfg_we,
    input  logic [ADDR_W-1:0]       cfg_addr,
    input  logic [STATE_W-1:0]      cfg_state,
    input  logic [DWELL_W-1:0]      cfg_dwell,
    input  logic [ADDR_W:0]         cfg_len,
    input  logic                    loop_en,
    input  logic                    sync_to_theta,
    input  logic                    start,
    input  logic                    abort,
    output logic [STATE_W-1:0]      state_select,
    output logic                    busy,
    output logic [ADDR_W-1:0]       entry_idx,
    output logic                    transition,
    output logic                    done
);

    localparam int LEN_W = ADDR_W + 1;
    localparam int TO_W  = $clog2(ALIGN_TIMEOUT + 1);

    sched_fsm_e         fsm_q, fsm_d;
    logic [STATE_W-1:0] sel_q, sel_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               trans_q, trans_d;
    logic               done_q, done_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               loop_q, loop_d;
    logic               sync_q, sync_d;
    logic [WIDTH-1:0]   theta_prev_q, theta_prev_d;

    logic [ADDR_W-1:0]  rd_addr;
    logic [STATE_W-1:0] rd_state;
    logic [DWELL_W-1:0] rd_dwell;
    logic [LEN_W-1:0]   next_idx_ext;
    logic               has_next;
    logic [ADDR_W-1:0]  next_addr;
    logic [LEN_W-1:0]   len_eff;
    logic               crossing;
    logic               advance;

    // Table is writable only while idle; codes and dwell are legalised on the way in.
    schedule_table_ram #(
        .ENTRIES (ENTRIES),
        .DWELL_W (DWELL_W)
    ) u_table (
        .clk        (clk),
        .wr_en_i    (cfg_we && (fsm_q == FSM_IDLE)),
        .wr_addr_i  (cfg_addr),
        .wr_state_i (legal_state(cfg_state)),
        .wr_dwell_i ((cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell),
        .rd_addr_i  (rd_addr),
        .rd_state_o (rd_state),
        .rd_dwell_o (rd_dwell)
    );

    // Successor entry: idx+1 while inside the latched length, otherwise wrap to 0.
    assign next_idx_ext = {1'b0, idx_q} + LEN_W'(1);
    assign has_next     = (next_idx_ext < len_q);
    assign next_addr    = has_next ? next_idx_ext[ADDR_W-1:0] : '0;
    assign rd_addr      = (fsm_q == FSM_IDLE) ? '0 : next_addr;
    assign len_eff      = (cfg_len > LEN_W'(ENTRIES)) ? LEN_W'(ENTRIES) : cfg_len;
    assign crossing     = clk_4khz_en && theta_prev_q[WIDTH-1] && !theta_in[WIDTH-1];

    // Next-state and output logic for the schedule sequencer.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        fsm_d        = fsm_q;
        sel_d        = sel_q;
        idx_d        = idx_q;
        busy_d       = busy_q;
        trans_d      = 1'b0;
        done_d       = 1'b0;
        dwell_d      = dwell_q;
        to_d         = to_q;
        len_d        = len_q;
        loop_d       = loop_q;
        sync_d       = sync_q;
        theta_prev_d = clk_4khz_en ? theta_in : theta_prev_q;
        advance      = 1'b0;

        case (fsm_q)
            FSM_IDLE: begin
                if (start && !abort) begin
                    len_d  = len_eff;
                    loop_d = loop_en;
                    sync_d = sync_to_theta;
                    if (len_eff != '0) begin
                        fsm_d   = FSM_DWELL;
                        sel_d   = rd_state;
                        idx_d   = '0;
                        busy_d  = 1'b1;
                        trans_d = 1'b1;
                        dwell_d = rd_dwell;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FSM_DWELL: begin
                if (clk_4khz_en) begin
                    if (dwell_q == DWELL_W'(1)) begin
                        if (sync_q) begin
                            fsm_d = FSM_ALIGN;
                            to_d  = '0;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        dwell_d = dwell_q - DWELL_W'(1);
                    end
                end
            end
            FSM_ALIGN: begin
                if (clk_4khz_en) begin
                    if (crossing || (to_q == TO_W'(ALIGN_TIMEOUT - 1))) begin
                        advance = 1'b1;
                    end else begin
                        to_d = to_q + TO_W'(1);
                    end
                end
            end
            FSM_FINISH: begin
                fsm_d = FSM_IDLE;
            end
            default: begin
                fsm_d = FSM_IDLE;
            end
        endcase

        if (advance) begin
            if (has_next || loop_q) begin
                fsm_d   = FSM_DWELL;
                sel_d   = rd_state;
                idx_d   = next_addr;
                trans_d = 1'b1;
                dwell_d = rd_dwell;
            end else begin
                fsm_d  = FSM_FINISH;
                done_d = 1'b1;
                busy_d = 1'b0;
                sel_d  = STATE_NORMAL;
                idx_d  = '0;
            end
        end

        // Abort overrides everything else and stays silent: no done, no transition.
        if (abort && (fsm_q != FSM_IDLE)) begin
            fsm_d   = FSM_IDLE;
            sel_d   = STATE_NORMAL;
            busy_d  = 1'b0;
            idx_d   = '0;
            trans_d = 1'b0;
            done_d  = 1'b0;
        end
    end

    // State register with synchronous reset; the table itself is untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q        <= FSM_IDLE;
            sel_q        <= STATE_NORMAL;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            trans_q      <= 1'b0;
            done_q       <= 1'b0;
            dwell_q      <= '0;
            to_q         <= '0;
            len_q        <= '0;
            loop_q       <= 1'b0;
            sync_q       <= 1'b0;
            theta_prev_q <= '0;
        end else begin
            fsm_q        <= fsm_d;
            sel_q        <= sel_d;
            idx_q        <= idx_d;
            busy_q       <= busy_d;
            trans_q      <= trans_d;
            done_q       <= done_d;
            dwell_q      <= dwell_d;
            to_q         <= to_d;
            len_q        <= len_d;
            loop_q       <= loop_d;
            sync_q       <= sync_d;
            theta_prev_q <= theta_prev_d;
        end
    end

    assign state_select = sel_q;
    assign busy         = busy_q;
    assign entry_idx    = idx_q;
    assign transition   = trans_q;
    assign done         = done_q;

endmodule

// File: tb/tb_state_schedule_controller.sv
// Randomised bench for state_schedule_controller. A table model plus a
// segment monitor (state shown, entry index, ticks held) is compared against
// the sequence the schedule rules predict.
module tb_state_schedule_controller;

    localparam int WIDTH         = 18;
    localparam int ENTRIES       = 16;
    localparam int DWELL_W       = 16;
    localparam int ALIGN_TIMEOUT = 1000;
    localparam int ADDR_W        = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    tick;
    logic signed [WIDTH-1:0] theta_in;
    logic                    cfg_we;
    logic [ADDR_W-1:0]       cfg_addr;
    logic [2:0]              cfg_state;
    logic [DWELL_W-1:0]      cfg_dwell;
    logic [ADDR_W:0]         cfg_len;
    logic                    loop_en;
    logic                    sync_to_theta;
    logic                    start;
    logic                    abort;
    logic [2:0]              state_select;
    logic                    busy;
    logic [ADDR_W-1:0]       entry_idx;
    logic                    transition;
    logic                    done;

    always #4 clk = ~clk;

    state_schedule_controller #(
        .WIDTH         (WIDTH),
        .ENTRIES       (ENTRIES),
        .DWELL_W       (DWELL_W),
        .ALIGN_TIMEOUT (ALIGN_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clk_4khz_en   (tick),
        .theta_in      (theta_in),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_state     (cfg_state),
        .cfg_dwell     (cfg_dwell),
        .cfg_len       (cfg_len),
        .loop_en       (loop_en),
        .sync_to_theta (sync_to_theta),
        .start         (start),
        .abort         (abort),
        .state_select  (state_select),
        .busy          (busy),
        .entry_idx     (entry_idx),
        .transition    (transition),
        .done          (done)
    );

    int checks = 0;
    int errors = 0;

    // Reference table, holding what the rules say each entry should contain.
    int m_state [ENTRIES];
    int m_dwell [ENTRIES];

    // Segment monitor.
    int obs_state [$];
    int obs_idx   [$];
    int obs_ticks [$];
    int trans_cnt, done_cnt, busy_seen, tot_ticks;
    bit seg_open;
    int seg_state, seg_idx, seg_ticks;
    int cyc, last_tick_cyc, mon_prev;
    bit last_cross, prev_busy, sync_mode;
    int align_checks, align_bad;

    // Stimulus generators.
    bit sine_on;
    int phase;
    int gap;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        obs_state.delete();
        obs_idx.delete();
        obs_ticks.delete();
        trans_cnt    = 0;
        done_cnt     = 0;
        busy_seen    = 0;
        tot_ticks    = 0;
        seg_open     = 1'b0;
        align_checks = 0;
        align_bad    = 0;
    endtask

    task automatic close_seg();
        obs_state.push_back(seg_state);
        obs_idx.push_back(seg_idx);
        obs_ticks.push_back(seg_ticks);
        seg_open = 1'b0;
    endtask

    // Observes one cycle at the falling edge.
    task automatic monitor();
        int th;
        cyc++;
        if (done === 1'b1) begin
            done_cnt++;
            if (seg_open) close_seg();
        end
        if (transition === 1'b1) begin
            trans_cnt++;
            if (seg_open) close_seg();
            if (sync_mode && prev_busy) begin
                align_checks++;
                if (!(last_tick_cyc == cyc - 1 && last_cross)) align_bad++;
            end
            seg_open  = 1'b1;
            seg_state = int'(state_select);
            seg_idx   = int'(entry_idx);
            seg_ticks = 0;
        end
        if (seg_open && busy !== 1'b1) seg_open = 1'b0;
        if (busy === 1'b1) busy_seen++;
        if (tick) begin
            th            = theta_in;
            last_cross    = (mon_prev < 0) && (th >= 0);
            mon_prev      = rst ? 0 : th;
            last_tick_cyc = cyc;
            if (seg_open) begin
                seg_ticks++;
                tot_ticks++;
            end
        end
        prev_busy = (busy === 1'b1);
    endtask

    // One clock: drive tick/theta, observe at negedge, return just after posedge.
    task automatic step();
        if (gap == 0) begin
            tick = 1'b1;
            gap  = $urandom_range(5, 2);
            if (sine_on) begin
                phase++;
                theta_in = WIDTH'($rtoi(6000.0 * $sin(6.283185307 * real'(phase) / 160.0)));
            end
        end else begin
            tick = 1'b0;
            gap--;
        end
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int addr, input int st, input int dw, input bit expect_store);
        cfg_we    = 1'b1;
        cfg_addr  = ADDR_W'(addr);
        cfg_state = 3'(st);
        cfg_dwell = DWELL_W'(dw);
        step();
        cfg_we = 1'b0;
        if (expect_store) begin
            m_state[addr] = (st > 4) ? 0 : st;
            m_dwell[addr] = (dw == 0) ? 1 : dw;
        end
    endtask

    // Starts a schedule, then scrambles the controls that should have been latched.
    task automatic start_sched(input int len, input bit lp, input bit sy);
        clear_mon();
        cfg_len       = 5'(len);
        loop_en       = lp;
        sync_to_theta = sy;
        start         = 1'b1;
        step();
        start         = 1'b0;
        cfg_len       = 5'($urandom_range(31));
        loop_en       = 1'($urandom);
        sync_to_theta = 1'($urandom);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) step();
        check(tag, done_cnt - d0, 1);
    endtask

    task automatic run_ticks(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && tot_ticks < n; i++) step();
        check(tag, tot_ticks >= n, 1);
    endtask

    task automatic do_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    // Compares observed segments with the expected entry order idx = k mod len.
    task automatic check_segments(input string tag, input int len, input int n_exp, input bit with_ticks);
        if (n_exp >= 0) check($sformatf("%s_nseg", tag), obs_state.size(), n_exp);
        foreach (obs_state[k]) begin
            int e = k % len;
            check($sformatf("%s_state%0d", tag, k), obs_state[k], m_state[e]);
            check($sformatf("%s_idx%0d", tag, k), obs_idx[k], e);
            if (with_ticks) check($sformatf("%s_ticks%0d", tag, k), obs_ticks[k], m_dwell[e]);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_sel"}, state_select, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_idx"}, entry_idx, 0);
        check({tag, "_trans"}, transition, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        rst = 1'b0; tick = 1'b0; theta_in = '0; cfg_we = 1'b0; cfg_addr = '0;
        cfg_state = '0; cfg_dwell = '0; cfg_len = '0; loop_en = 1'b0;
        sync_to_theta = 1'b0; start = 1'b0; abort = 1'b0;
        sine_on = 1'b0; phase = 0; gap = 2; cyc = 0; mon_prev = 0;
        last_tick_cyc = -10; last_cross = 1'b0; prev_busy = 1'b0; sync_mode = 1'b0;
        clear_mon();
        @(posedge clk);
        #1;

        // 1. Reset values, then an empty schedule.
        rst = 1'b1;
        step();
        step();
        check_idle_outputs("reset");
        rst = 1'b0;
        step();
        start_sched(0, 1'b0, 1'b0);
        repeat (4) step();
        check("len0_done", done_cnt, 1);
        check("len0_busy_seen", busy_seen, 0);
        check("len0_sel", state_select, 0);
        check("len0_trans", trans_cnt, 0);

        // 2. Two-entry one-shot schedule.
        write_entry(0, 4, 100, 1'b1);
        write_entry(1, 0, 50, 1'b1);
        start_sched(2, 1'b0, 1'b0);
        wait_done("oneshot_done", 3000);
        repeat (3) step();
        check("oneshot_done_cnt", done_cnt, 1);
        check("oneshot_trans_cnt", trans_cnt, 2);
        check("oneshot_busy", busy, 0);
        check("oneshot_sel", state_select, 0);
        check_segments("oneshot", 2, 2, 1'b1);

        // 3. Same table looping for 500 ticks.
        start_sched(2, 1'b1, 1'b0);
        run_ticks("loop_ticks", 500, 5000);
        do_abort();
        check_idle_outputs("loop_abort");
        check("loop_done_cnt", done_cnt, 0);
        check("loop_nseg_ge6", obs_state.size() >= 6, 1);
        check_segments("loop", 2, -1, 1'b1);

        // 4a. Transitions gated on upward theta crossings.
        write_entry(0, 4, 10, 1'b1);
        write_entry(1, 0, 10, 1'b1);
        sine_on   = 1'b1;
        phase     = $urandom_range(159);
        sync_mode = 1'b1;
        start_sched(2, 1'b1, 1'b1);
        for (int i = 0; i < 20000 && trans_cnt < 8; i++) step();
        check("sync_trans_cnt", trans_cnt >= 8, 1);
        check("sync_align_checks", align_checks >= 5, 1);
        check("sync_align_bad", align_bad, 0);
        check_segments("sync", 2, -1, 1'b0);
        do_abort();
        sync_mode = 1'b0;
        sine_on   = 1'b0;

        // 4b. No crossing ever: forced after the timeout.
        theta_in = -18'sd1000;
        write_entry(0, 3, 10, 1'b1);
        start_sched(1, 1'b0, 1'b1);
        wait_done("timeout_done", 8000);
        check("timeout_nseg", obs_ticks.size(), 1);
        if (obs_ticks.size() > 0) check("timeout_ticks", obs_ticks[0], 10 + ALIGN_TIMEOUT);

        // 5a. Abort together with start mid-dwell.
        write_entry(0, 4, 30, 1'b1);
        write_entry(1, 2, 20, 1'b1);
        start_sched(2, 1'b0, 1'b0);
        run_ticks("abort_ticks", 10, 500);
        abort = 1'b1;
        start = 1'b1;
        step();
        check_idle_outputs("abort_start");
        abort = 1'b0;
        start = 1'b0;
        repeat (4) step();
        check("abort_busy", busy, 0);
        check("abort_done_cnt", done_cnt, 0);
        check("abort_trans_cnt", trans_cnt, 1);

        // 5b. Writes while busy are dropped.
        start_sched(2, 1'b1, 1'b0);
        run_ticks("busywr_ticks", 5, 500);
        write_entry(0, 1, 3, 1'b0);
        write_entry(1, 3, 7, 1'b0);
        do_abort();
        start_sched(2, 1'b0, 1'b0);
        wait_done("busywr_done", 2000);
        check_segments("busywr", 2, 2, 1'b1);

        // 6a. dwell 0 runs as 1 tick, code 7 runs as NORMAL.
        write_entry(0, 7, 0, 1'b1);
        write_entry(1, 3, 2, 1'b1);
        start_sched(2, 1'b0, 1'b0);
        wait_done("legal_done", 500);
        check_segments("legal", 2, 2, 1'b1);

        // 6b. Length above ENTRIES is clamped.
        for (int a = 0; a < ENTRIES; a++) write_entry(a, $urandom_range(7), $urandom_range(3), 1'b1);
        start_sched(ENTRIES + 1, 1'b0, 1'b0);
        wait_done("clamp_done", 2000);
        check("clamp_trans_cnt", trans_cnt, ENTRIES);
        check_segments("clamp", ENTRIES, ENTRIES, 1'b1);

        // 6c. Reset mid-schedule, table preserved.
        start_sched(ENTRIES, 1'b1, 1'b0);
        run_ticks("rst_ticks", 5, 500);
        rst = 1'b1;
        step();
        step();
        check_idle_outputs("midrst");
        rst = 1'b0;
        step();
        check_idle_outputs("midrst_rel");
        start_sched(ENTRIES, 1'b0, 1'b0);
        wait_done("rerun_done", 2000);
        check_segments("rerun", ENTRIES, ENTRIES, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
